// File: rtl/msp_spi_master.sv
// Half-duplex single-data-line SPI initiator that plays the MSP side of the ICE40 link.
// Sends a command, releases the line for a turnaround, then optionally reads a response.
module msp_spi_master #(
   parameter int CLK_DIV     = 4,
   parameter int MSG_LEN     = 64,
   parameter int RESP_LEN    = 64,
   parameter int TURN_CYCLES = 8
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic                cmd_trigger,
   input  logic [MSG_LEN-1:0]  cmd_msg,
   input  logic                cmd_resp_en,
   output logic                cmd_ready,
   output logic                resp_done,
   output logic [RESP_LEN-1:0] resp_data,
   output logic                spi_clk,
   output logic                spi_data_out,
   output logic                spi_data_oe,
   input  logic                spi_data_in
);

   localparam int MAX1 = (MSG_LEN > RESP_LEN) ? MSG_LEN : RESP_LEN;
   localparam int MAXL = (MAX1 > TURN_CYCLES) ? MAX1 : TURN_CYCLES;
   localparam int BW   = $clog2(MAXL + 1);
   localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_TOP  = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] MSG_TOP  = BW'(MSG_LEN - 1);
   localparam logic [BW-1:0] TURN_TOP = BW'(TURN_CYCLES - 1);
   localparam logic [BW-1:0] RESP_TOP = BW'(RESP_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX,
      S_TURN,
      S_RX,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [DW-1:0]       r_div;
   logic [BW-1:0]       r_bits;
   logic                r_sclk;
   logic                r_sdo;
   logic                r_oe;
   logic                r_done;
   logic                r_resp_en;
   logic [1:0]          r_sync;
   logic                r_samp;
   logic                r_last;
   logic [MSG_LEN-1:0]  r_tx;
   logic [RESP_LEN-1:0] r_rx;
   logic [RESP_LEN-1:0] r_resp;

   logic w_run;
   logic w_wrap;
   logic w_fall;
   logic w_rise;
   logic w_accept;

   assign w_run    = (r_state == S_TX) || (r_state == S_TURN) ||
                     (r_state == S_RX);
   assign w_wrap   = (r_div == DIV_TOP);
   assign w_fall   = w_run && w_wrap && r_sclk;
   assign w_rise   = w_run && w_wrap && !r_sclk;
   assign w_accept = (r_state == S_IDLE) && cmd_trigger;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (cmd_trigger) w_next = S_TX;
         S_TX:   if (w_rise && r_bits == MSG_TOP) w_next = S_TURN;
         S_TURN: if (w_rise && r_bits == TURN_TOP)
                    w_next = r_resp_en ? S_RX : S_DONE;
         S_RX:   if (w_rise && r_bits == RESP_TOP) w_next = S_DONE;
         S_DONE: if (r_done) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_div     <= '0;
         r_bits    <= '0;
         r_sclk    <= 1'b1;
         r_sdo     <= 1'b1;
         r_oe      <= 1'b0;
         r_done    <= 1'b0;
         r_resp_en <= 1'b0;
         r_sync    <= '0;
         r_samp    <= 1'b0;
         r_last    <= 1'b0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_resp    <= '0;
      end else begin
         r_sync <= {r_sync[0], spi_data_in};
         r_done <= (r_state == S_DONE) && w_wrap && !r_done;
         // sample one clk after the rise so the 2-flop sync has settled
         r_samp <= w_rise && (r_state == S_RX);
         r_last <= w_rise && (r_state == S_RX) && (r_bits == RESP_TOP);

         if (r_state == S_IDLE) r_div <= '0;
         else if (w_wrap)       r_div <= '0;
         else                   r_div <= r_div + 1'b1;

         if (w_run && w_wrap) r_sclk <= ~r_sclk;

         if (w_accept) begin
            r_tx      <= cmd_msg;
            r_resp_en <= cmd_resp_en;
            r_oe      <= 1'b1;
            r_bits    <= '0;
         end

         if (w_fall && r_state == S_TX) begin
            r_sdo <= r_tx[MSG_LEN-1];
            r_tx  <= {r_tx[MSG_LEN-2:0], 1'b0};
         end

         if (w_fall && r_state == S_TURN) begin
            r_oe  <= 1'b0;
            r_sdo <= 1'b1;
         end

         if (w_rise) begin
            if (w_next != r_state) r_bits <= '0;
            else                   r_bits <= r_bits + 1'b1;
         end

         if (r_samp) r_rx <= {r_rx[RESP_LEN-2:0], r_sync[1]};
         if (r_last) r_resp <= {r_rx[RESP_LEN-2:0], r_sync[1]};
      end
   end

   assign cmd_ready    = (r_state == S_IDLE);
   assign resp_done    = r_done;
   assign resp_data    = r_resp;
   assign spi_clk      = r_sclk;
   assign spi_data_out = r_sdo;
   assign spi_data_oe  = r_oe;

endmodule

// File: tb/tb_msp_spi_master.sv
// Directed bench for msp_spi_master with a behavioural half-duplex slave.
// Decodes the command stream and returns a response after the turnaround.
module tb_msp_spi_master;

   localparam int DIV = 2;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic        cmd_trigger = 1'b0;
   logic [63:0] cmd_msg = '0;
   logic        cmd_resp_en = 1'b0;
   logic        cmd_ready;
   logic        resp_done;
   logic [63:0] resp_data;
   logic        spi_clk;
   logic        spi_data_out;
   logic        spi_data_oe;
   logic        spi_data_in = 1'b1;

   msp_spi_master #(
      .CLK_DIV(DIV), .MSG_LEN(64), .RESP_LEN(64), .TURN_CYCLES(8)
   ) u_dut (
      .clk(clk), .rst_(rst_),
      .cmd_trigger(cmd_trigger), .cmd_msg(cmd_msg),
      .cmd_resp_en(cmd_resp_en), .cmd_ready(cmd_ready),
      .resp_done(resp_done), .resp_data(resp_data),
      .spi_clk(spi_clk), .spi_data_out(spi_data_out),
      .spi_data_oe(spi_data_oe), .spi_data_in(spi_data_in)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          rise_cnt = 0;
   int          base = 0;
   int          oe_bad = 0;
   int          done_cnt = 0;
   int          hi_run = 0;
   int          first_gap = 0;
   logic [63:0] cmd_cap = '0;
   logic [63:0] slv_resp = '0;
   logic        slv_en = 1'b0;

   // slave: captures command bits on rising edges, drives reply after falls
   always @(posedge spi_clk) begin
      int k;
      k = rise_cnt + 1 - base;
      rise_cnt <= rise_cnt + 1;
      if (k <= 64) begin
         cmd_cap <= {cmd_cap[62:0], spi_data_out};
         if (!spi_data_oe) oe_bad <= oe_bad + 1;
      end else if (spi_data_oe) begin
         oe_bad <= oe_bad + 1;
      end
   end

   always @(negedge spi_clk) begin
      int k;
      k = rise_cnt - base;
      if (slv_en && k >= 72 && k < 136) spi_data_in <= slv_resp[135-k];
   end

   always @(posedge clk) if (resp_done) done_cnt <= done_cnt + 1;

   always @(negedge clk) begin
      if (spi_clk) hi_run <= hi_run + 1;
      else begin
         if (hi_run != 0 && rise_cnt == base) first_gap <= hi_run;
         hi_run <= 0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_txn(input string tag, input logic [63:0] msg,
                          input logic en, input logic [63:0] rsp,
                          input logic [63:0] exp_rd, input int busy_at,
                          input bit chk_gap);
      int d0, ob0, t;
      bit seen;
      t = 0;
      while (!cmd_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_ready"}, cmd_ready, 1);
      base = rise_cnt;
      d0 = done_cnt;
      ob0 = oe_bad;
      slv_en = en;
      slv_resp = rsp;
      cmd_msg = msg;
      cmd_resp_en = en;
      cmd_trigger = 1'b1;
      @(negedge clk);
      cmd_trigger = 1'b0;
      chk({tag, "_busy"}, cmd_ready, 0);
      seen = 0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         if (i == busy_at) begin
            cmd_trigger = 1'b1;
            cmd_msg = ~msg;
            cmd_resp_en = ~en;
         end else begin
            cmd_trigger = 1'b0;
         end
         @(negedge clk);
         if (resp_done) seen = 1;
      end
      cmd_trigger = 1'b0;
      chk({tag, "_done"}, seen, 1);
      chk({tag, "_cmd"}, cmd_cap, msg);
      chk({tag, "_rises"}, rise_cnt - base, en ? 136 : 72);
      chk({tag, "_resp"}, resp_data, exp_rd);
      chk({tag, "_rdy_lo"}, cmd_ready, 0);
      chk({tag, "_oe"}, oe_bad - ob0, 0);
      if (chk_gap) chk({tag, "_gap"}, first_gap >= DIV, 1);
      @(negedge clk);
      chk({tag, "_rdy_hi"}, cmd_ready, 1);
      chk({tag, "_pulse_lo"}, resp_done, 0);
      chk({tag, "_npulse"}, done_cnt - d0, 1);
   endtask

   initial begin
      int d0, t;
      repeat (5) @(negedge clk);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_sclk", spi_clk, 1);
      chk("rst_oe", spi_data_oe, 0);
      chk("rst_sdo", spi_data_out, 1);
      chk("rst_resp", resp_data, 0);
      chk("rst_done", resp_done, 0);
      rst_ = 1'b1;
      repeat (2) @(negedge clk);

      run_txn("cmdonly", 64'hA500_0000_0000_003C, 1'b0, 64'h0,
              64'h0, -1, 1'b0);
      run_txn("cmdresp", 64'hA500_0000_0000_003C, 1'b1,
              64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, -1, 1'b0);
      run_txn("hold", 64'h8000_0000_0000_0001, 1'b0, 64'h0,
              64'hDEAD_BEEF_0123_4567, -1, 1'b0);
      run_txn("busytrig", 64'h0123_4567_89AB_CDEF, 1'b1,
              64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 20, 1'b0);

      // abort in the middle of the response
      base = rise_cnt;
      d0 = done_cnt;
      slv_en = 1'b1;
      slv_resp = 64'hCAFE_F00D_1234_5678;
      cmd_msg = 64'h1111_2222_3333_4444;
      cmd_resp_en = 1'b1;
      cmd_trigger = 1'b1;
      @(negedge clk);
      cmd_trigger = 1'b0;
      t = 0;
      while (rise_cnt - base < 93 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("abort_reach", rise_cnt - base, 93);
      rst_ = 1'b0;
      #1;
      chk("abort_sclk", spi_clk, 1);
      chk("abort_oe", spi_data_oe, 0);
      chk("abort_resp", resp_data, 0);
      chk("abort_ready", cmd_ready, 1);
      repeat (5) @(negedge clk);
      rst_ = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_nodone", done_cnt - d0, 0);
      chk("abort_hold", resp_data, 0);

      run_txn("recover", 64'hFEDC_BA98_7654_3210, 1'b1,
              64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, -1, 1'b0);
      run_txn("b2b_a", 64'h5A5A_5A5A_A5A5_A5A5, 1'b1,
              64'h5555_AAAA_3C3C_C3C3, 64'h5555_AAAA_3C3C_C3C3, -1, 1'b1);
      run_txn("b2b_b", 64'hC3C3_0000_FFFF_1234, 1'b1,
              64'h0F0F_0F0F_F0F0_F0F0, 64'h0F0F_0F0F_F0F0_F0F0, -1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
